// File: rtl/nabp_fir_filter.sv
// Direct-form FIR stage for the projection lane: loadable signed taps, fixed
// three-stage pipeline, round-half-up and saturation to the filtered width, and a bypass path.
module nabp_fir_filter #(
  parameter int pDataLength         = 12,
  parameter int pFilteredDataLength = 16,
  parameter int pNumTaps            = 8,
  parameter int pTapPtrLength       = 3,
  parameter int pCoeffLength        = 12,
  parameter int pCoeffFrac          = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic                           bypass,
  input  logic [pDataLength-1:0]         val_in,
  input  logic                           coeff_wr_en,
  input  logic [pTapPtrLength-1:0]       coeff_wr_addr,
  input  logic [pCoeffLength-1:0]        coeff_wr_data,
  output logic [pFilteredDataLength-1:0] val_out,
  output logic                           sat
);

  localparam int CENTRE = (pNumTaps - 1) / 2;
  localparam int PW     = pDataLength + pCoeffLength;
  localparam int AW     = PW + $clog2(pNumTaps);
  localparam int OW     = pFilteredDataLength;

  localparam logic signed [pCoeffLength-1:0] COEFF_ONE  = pCoeffLength'(1 << pCoeffFrac);
  localparam logic signed [AW-1:0]           ROUND_HALF = AW'(1) << (pCoeffFrac - 1);
  localparam logic signed [OW-1:0]           OUT_MAX    = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0]           OUT_MIN    = {1'b1, {(OW-1){1'b0}}};

  logic signed [pDataLength-1:0]  x     [pNumTaps];
  logic signed [pCoeffLength-1:0] coeff [pNumTaps];
  logic signed [PW-1:0]           prod  [pNumTaps];
  logic signed [pDataLength-1:0]  byp_q;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] rounded;
  logic signed [OW-1:0] filt;
  logic                 filt_sat;

  // NOTE: the coefficient bank is built from flops rather than a RAM precisely so
  // that reset can restore the centre-only (pass-through) response in one step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < pNumTaps; k++) begin
        coeff[k] <= (k == CENTRE) ? COEFF_ONE : '0;
      end
    end else if (coeff_wr_en) begin
      // Addresses beyond the last tap match no k and are dropped.
      for (int k = 0; k < pNumTaps; k++) begin
        if (int'(coeff_wr_addr) == k) begin
          coeff[k] <= coeff_wr_data;
        end
      end
    end
  end

  // NOTE: non-blocking updates mean a coefficient written on the same edge as an
  // enabled multiply is not yet visible to it; the product uses the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < pNumTaps; k++) begin
        x[k]    <= '0;
        prod[k] <= '0;
      end
      byp_q <= '0;
    end else if (enable) begin
      x[0] <= val_in;
      for (int k = 1; k < pNumTaps; k++) begin
        x[k] <= x[k-1];
      end
      for (int k = 0; k < pNumTaps; k++) begin
        prod[k] <= PW'(x[k]) * PW'(coeff[k]);
      end
      byp_q <= x[CENTRE];
    end
  end

  // NOTE: every variable is given a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    acc = '0;
    for (int k = 0; k < pNumTaps; k++) begin
      acc = acc + AW'(prod[k]);
    end
    rounded  = (acc + ROUND_HALF) >>> pCoeffFrac;
    filt     = rounded[OW-1:0];
    filt_sat = 1'b0;
    // Out of range exactly when the truncated value no longer sign-extends back.
    if (AW'(filt) != rounded) begin
      filt_sat = 1'b1;
      filt     = rounded[AW-1] ? OUT_MIN : OUT_MAX;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_out <= '0;
      sat     <= 1'b0;
    end else if (enable) begin
      if (bypass) begin
        val_out <= OW'(byp_q);
        sat     <= 1'b0;
      end else begin
        val_out <= filt;
        sat     <= filt_sat;
      end
    end
  end

endmodule

// File: tb/tb_nabp_fir_filter.sv
// Scoreboard bench for nabp_fir_filter: a driver predicts each cycle's output from
// sample/coefficient history; a monitor compares the DUT against those predictions.
module tb_nabp_fir_filter;

  localparam int N_TAPS = 8;
  localparam int C      = (N_TAPS - 1) / 2;

  typedef int coef_t [N_TAPS];
  typedef struct {
    int v;
    int s;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        bypass = 1'b0;
  logic [11:0] val_in = '0;
  logic        coeff_wr_en = 1'b0;
  logic [2:0]  coeff_wr_addr = '0;
  logic [11:0] coeff_wr_data = '0;
  logic [15:0] val_out;
  logic        sat;

  nabp_fir_filter dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .bypass        (bypass),
    .val_in        (val_in),
    .coeff_wr_en   (coeff_wr_en),
    .coeff_wr_addr (coeff_wr_addr),
    .coeff_wr_data (coeff_wr_data),
    .val_out       (val_out),
    .sat           (sat)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  bit    running  = 1'b0;
  exp_t  exp_q[$];
  exp_t  last_exp;
  int    in_hist[$];
  coef_t hc_hist[$];
  coef_t h_now;
  coef_t h_rst;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
  endtask

  function automatic int in_at(input int i);
    return (i < 1) ? 0 : in_hist[i-1];
  endfunction

  // Output after the n-th enabled edge: tap k sees the sample taken 2+k edges
  // earlier times the coefficient held just before edge n-1; bypass sees tap C.
  function automatic exp_t predict(input int n, input bit byp);
    exp_t  e;
    coef_t hv;
    longint s, r, q;
    if (byp) begin
      e.v = in_at(n - 2 - C);
      e.s = 0;
      return e;
    end
    hv = (n - 1 < 1) ? h_rst : hc_hist[n-2];
    s = 0;
    for (int k = 0; k < N_TAPS; k++) s += longint'(in_at(n - 2 - k)) * longint'(hv[k]);
    r = s + 128;
    q = (r >= 0) ? r / 256 : -((-r + 255) / 256);
    e.s = 0;
    if (q > 32767)       begin q = 32767;  e.s = 1; end
    else if (q < -32768) begin q = -32768; e.s = 1; end
    e.v = int'(q);
    return e;
  endfunction

  task automatic model_reset();
    in_hist.delete();
    hc_hist.delete();
    exp_q.delete();
    h_now    = h_rst;
    last_exp = '{v: 0, s: 0};
  endtask

  task automatic step(input bit en, input bit byp, input int vin,
                      input bit we = 1'b0, input int wa = 0, input int wd = 0);
    @(negedge clk);
    enable        = en;
    bypass        = byp;
    val_in        = 12'(vin);
    coeff_wr_en   = we;
    coeff_wr_addr = 3'(wa);
    coeff_wr_data = 12'(wd);
    if (en) begin
      hc_hist.push_back(h_now);
      in_hist.push_back(vin);
      last_exp = predict(in_hist.size(), byp);
    end
    exp_q.push_back(last_exp);
    @(posedge clk);
    if (we && wa < N_TAPS) h_now[wa] = wd;
  endtask

  task automatic expect_now(input string name, input int v, input int s);
    #2;
    check({name, "_val"}, int'($signed(val_out)), v);
    check({name, "_sat"}, int'(sat), s);
  endtask

  task automatic write_all(input int wd);
    for (int k = 0; k < N_TAPS; k++) step(1'b0, 1'b0, 0, 1'b1, k, wd);
  endtask

  // Called straight after a step returns, so the assertion lands mid-high-phase.
  task automatic async_reset();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_val", int'($signed(val_out)), 0);
    check("async_rst_sat", int'(sat), 0);
    enable      = 1'b0;
    coeff_wr_en = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (running && reset_n) begin
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: no prediction at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("sb_val", int'($signed(val_out)), e.v);
          check("sb_sat", int'(sat), e.s);
        end
      end
    end
  end

  initial begin : driver
    for (int k = 0; k < N_TAPS; k++) h_rst[k] = (k == C) ? 256 : 0;
    model_reset();
    #1;
    check("reset_val", int'($signed(val_out)), 0);
    check("reset_sat", int'(sat), 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    running = 1'b1;

    // Impulse through the reset (centre-only) coefficients.
    step(1'b1, 1'b0, 100);
    repeat (5) step(1'b1, 1'b0, 0);
    expect_now("impulse_peak", 100, 0);
    repeat (4) step(1'b1, 1'b0, 0);
    expect_now("impulse_tail", 0, 0);

    // Unity on every tap: a held step ramps to 8x, bypass gives the raw sample.
    write_all(256);
    repeat (10) step(1'b1, 1'b0, 100);
    expect_now("step_full", 800, 0);
    repeat (3) step(1'b1, 1'b0, 100);
    expect_now("step_hold", 800, 0);
    step(1'b1, 1'b1, 100);
    expect_now("step_bypass", 100, 0);

    // Saturation at both rails.
    write_all(2047);
    repeat (12) step(1'b1, 1'b0, 2047);
    expect_now("sat_pos", 32767, 1);
    repeat (12) step(1'b1, 1'b0, -2048);
    expect_now("sat_neg", -32768, 1);

    // Round half up on the centre tap at 0.5.
    for (int k = 0; k < N_TAPS; k++) step(1'b0, 1'b0, 0, 1'b1, k, (k == C) ? 128 : 0);
    repeat (8) step(1'b1, 1'b0, 3);
    expect_now("round_p3", 2, 0);
    repeat (8) step(1'b1, 1'b0, -3);
    expect_now("round_m3", -1, 0);
    repeat (8) step(1'b1, 1'b0, 1);
    expect_now("round_p1", 1, 0);

    // Stall mid-pipeline with a coefficient write that lands before tap C multiplies.
    step(1'b0, 1'b0, 0, 1'b1, C, 256);
    repeat (10) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 100);
    repeat (2) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b1, C, 512);
    repeat (3) step(1'b0, 1'b0, 0);
    repeat (3) step(1'b1, 1'b0, 0);
    expect_now("stall_impulse", 200, 0);

    // Randomised traffic: stalls, mode switches, writes racing enabled edges.
    repeat (400) begin
      bit en, byp, we;
      en  = ($urandom_range(0, 9) < 8);
      byp = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 9) == 0);
      step(en, byp, int'($urandom_range(0, 4095)) - 2048,
           we, int'($urandom_range(0, N_TAPS - 1)), int'($urandom_range(0, 4095)) - 2048);
    end

    // Async reset while streaming, then confirm the centre-only taps are back.
    write_all(300);
    repeat (8) step(1'b1, 1'b1, 500);
    expect_now("pre_reset", 500, 0);
    step(1'b1, 1'b0, 500);
    async_reset();
    step(1'b1, 1'b0, 100);
    repeat (5) step(1'b1, 1'b0, 0);
    expect_now("post_reset_impulse", 100, 0);
    repeat (3) step(1'b1, 1'b0, 0);

    @(negedge clk);
    running = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nabp_fir_filter.md
Name: nabp_fir_filter

Overview:
- Parametrised successor to the delay-only projection filter stage: a real direct-form FIR with run-time loadable signed coefficients, fixed pipeline latency, round/saturate to the filtered width, and a bypass mode.
- Sits between the projection data stream and the back-projection datapath; clocked and stalled by the same enable as the rest of the lane.

Parameters:
- pDataLength, 12, signed input sample width.
- pFilteredDataLength, 16, signed output width.
- pNumTaps, 8, tap count (>=2).
- pTapPtrLength, 3, coefficient address width (>= clog2(pNumTaps)).
- pCoeffLength, 12, signed coefficient width.
- pCoeffFrac, 8, coefficient fraction bits; 1.0 = 1<<pCoeffFrac.

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, advance datapath this cycle.
- bypass, in, 1, 1 = pure group delay, no filtering.
- val_in, in, pDataLength, signed sample.
- coeff_wr_en, in, 1, coefficient write strobe.
- coeff_wr_addr, in, pTapPtrLength, tap index.
- coeff_wr_data, in, pCoeffLength, signed coefficient.
- val_out, out, pFilteredDataLength, signed filtered sample.
- sat, out, 1, val_out of this update was saturated.

Behaviour:
- Reset (async, reset_n=0): delay line, product and sum registers, val_out and sat cleared to 0. Coefficients reset to h[C]=1<<pCoeffFrac with C=(pNumTaps-1)/2; all other taps 0. After reset, filter mode therefore equals bypass mode.
- All datapath registers update only on rising clk with enable=1. With enable=0 every datapath register, val_out and sat hold.
- Stage 1: delay line shifts; x[0]<=val_in, x[k]<=x[k-1].
- Stage 2: p[k]<=x[k]*h[k], signed and full precision (pDataLength+pCoeffLength bits).
- Stage 3:
  - Sum S over all p[k] in an accumulator of product width + clog2(pNumTaps) bits. No intermediate overflow.
  - Round half up: R=(S+(1<<(pCoeffFrac-1)))>>>pCoeffFrac (arithmetic shift).
  - Saturate R to the signed pFilteredDataLength range; sat<=1 if clamped, else 0.
  - Register result to val_out.
- Latency: a sample on an enabled edge contributes via tap k to val_out after 3+k enabled edges. Impulse response appears at the output as h[0..pNumTaps-1].
- Bypass:
  - Registers the sign-extended x[C] through two matching stages.
  - val_out equals the input delayed 3+C enabled edges, same as the filter's centre tap. sat=0 in bypass.
  - Both paths run continuously. bypass is sampled at stage 3 only, so a mode switch takes effect on the next enabled edge with no pipeline flush.
- Coefficient writes:
  - Independent of enable.
  - h[coeff_wr_addr]<=coeff_wr_data on a clk edge with coeff_wr_en=1.
  - The new value is used by the stage-2 multiply on the next enabled edge after the write.
  - Address >= pNumTaps: write ignored.
  - Write and enable in the same cycle: the product uses the old coefficient.
- reset_n asserted mid-stream: immediate clear as above, including coefficient restore. Pipeline refills from zero.
- Widths: inputs and outputs are two's complement. val_out is never truncated without the saturation check.

Test Plan (default parameters, C=3):
- Reset, then enable=1, val_in=100 for one cycle, 0 afterwards -> val_out=100 on exactly the 6th enabled edge only, 0 otherwise; sat=0.
- Write h[0..7]=256; step val_in=100 held -> val_out=100,200,...,800 on enabled edges 3..10, then holds 800; bypass=1 then gives val_out=100.
- Write h[0..7]=2047; val_in=2047 held -> val_out=32767 with sat=1 once the pipeline fills; val_in=-2048 -> val_out=-32768, sat=1.
- Rounding, h[3]=128, others 0: val_in=3 -> val_out=2; val_in=-3 -> val_out=-1; val_in=1 -> val_out=1.
- Impulse 100 with enable deasserted for 5 cycles mid-pipeline -> val_out and sat hold during the stall; the impulse still emerges after 6 enabled edges. Coefficient write during the stall is applied on resumption.
- Assert reset_n low asynchronously, mid-clock, during streaming -> val_out=0 and sat=0 immediately. h restored to centre-only, verified by impulse 100 returning 100 at the 6th enabled edge.
